// File: rtl/rtc_bus_responder.sv
// Bus-side stand-in for the external RTC chip: synchronised A_D/CS/RD/WR bus
// decode, register file and BCD time/date counting from a clk-derived tick.
module rtc_bus_responder #(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       CS,
    input  logic       RD,
    input  logic       WR,
    input  logic       A_D,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_drive,
    output logic       sec_tick
);

    localparam int unsigned DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    typedef enum logic [7:0] {
        ADDR_CTRL  = 8'h00,
        ADDR_SEC   = 8'h21,
        ADDR_MIN   = 8'h22,
        ADDR_HOUR  = 8'h23,
        ADDR_DAY   = 8'h24,
        ADDR_MONTH = 8'h25,
        ADDR_YEAR  = 8'h26
    } reg_addr_e;

    logic       cs_s1, cs_s2, rd_s1, rd_s2, wr_s1, wr_s2, wr_prev;
    logic       ad_s1, ad_s2;
    logic [7:0] bus_s1, bus_s2;

    logic [7:0] addr_latch, ctrl;
    logic [7:0] sec, min, hour, day, month, year;
    logic [7:0] sec_n, min_n, hour_n, day_n, month_n, year_n, ctrl_n, addr_n;
    logic [DW-1:0] div;
    logic       tick_pending, tick_pending_n;

    logic       write_ev, addr_write, data_write, read_active;
    logic       tick_raw, tick_now;
    logic [7:0] read_val;

    // Returns {carry, next}; anything at or above hi (including non-BCD) wraps.
    function automatic logic [8:0] bcd_inc(input logic [7:0] val,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
        if (val >= hi)
            return {1'b1, lo};
        else if (val[3:0] == 4'h9)
            return {1'b0, val[7:4] + 4'h1, 4'h0};
        else
            return {1'b0, val + 8'h01};
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            rd_s1   <= 1'b1;
            rd_s2   <= 1'b1;
            wr_s1   <= 1'b1;
            wr_s2   <= 1'b1;
            wr_prev <= 1'b1;
            ad_s1   <= 1'b0;
            ad_s2   <= 1'b0;
            bus_s1  <= '0;
            bus_s2  <= '0;
        end else begin
            cs_s1   <= CS;
            cs_s2   <= cs_s1;
            rd_s1   <= RD;
            rd_s2   <= rd_s1;
            wr_s1   <= WR;
            wr_s2   <= wr_s1;
            wr_prev <= wr_s2;
            ad_s1   <= A_D;
            ad_s2   <= ad_s1;
            bus_s1  <= bus_in;
            bus_s2  <= bus_s1;
        end
    end

    assign write_ev    = !cs_s2 && wr_prev && !wr_s2;
    assign addr_write  = write_ev && !ad_s2;
    assign data_write  = write_ev && ad_s2;
    assign read_active = !cs_s2 && !rd_s2 && wr_s2 && ad_s2;

    assign tick_raw = !ctrl[0] && (div == DIV_LAST);
    // A tick landing on a data write is held back one cycle so the cascade
    // sees the freshly written value instead of racing it.
    assign tick_now = (tick_raw && !data_write) || tick_pending;
    assign sec_tick = tick_now;

    always_comb begin
        logic [8:0] r;
        logic       c;
        sec_n          = sec;
        min_n          = min;
        hour_n         = hour;
        day_n          = day;
        month_n        = month;
        year_n         = year;
        ctrl_n         = ctrl;
        addr_n         = addr_latch;
        tick_pending_n = tick_raw && data_write;
        r              = '0;
        c              = 1'b0;

        if (tick_now) begin
            r = bcd_inc(sec, 8'h00, 8'h59);
            sec_n = r[7:0];
            c = r[8];
            if (c) begin
                r = bcd_inc(min, 8'h00, 8'h59);
                min_n = r[7:0];
                c = r[8];
            end
            if (c) begin
                r = bcd_inc(hour, 8'h00, 8'h23);
                hour_n = r[7:0];
                c = r[8];
            end
            if (c) begin
                r = bcd_inc(day, 8'h01, 8'h31);
                day_n = r[7:0];
                c = r[8];
            end
            if (c) begin
                r = bcd_inc(month, 8'h01, 8'h12);
                month_n = r[7:0];
                c = r[8];
            end
            if (c) begin
                r = bcd_inc(year, 8'h00, 8'h99);
                year_n = r[7:0];
            end
        end

        if (addr_write)
            addr_n = bus_s2;

        if (data_write) begin
            case (addr_latch)
                ADDR_CTRL:  ctrl_n  = bus_s2;
                ADDR_SEC:   sec_n   = bus_s2;
                ADDR_MIN:   min_n   = bus_s2;
                ADDR_HOUR:  hour_n  = bus_s2;
                ADDR_DAY:   day_n   = bus_s2;
                ADDR_MONTH: month_n = bus_s2;
                ADDR_YEAR:  year_n  = bus_s2;
                default:    ;
            endcase
        end
    end

    always_comb begin
        read_val = '0;
        case (addr_latch)
            ADDR_CTRL:  read_val = ctrl;
            ADDR_SEC:   read_val = sec;
            ADDR_MIN:   read_val = min;
            ADDR_HOUR:  read_val = hour;
            ADDR_DAY:   read_val = day;
            ADDR_MONTH: read_val = month;
            ADDR_YEAR:  read_val = year;
            default:    read_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_latch   <= '0;
            ctrl         <= '0;
            sec          <= '0;
            min          <= '0;
            hour         <= '0;
            day          <= 8'h01;
            month        <= 8'h01;
            year         <= '0;
            tick_pending <= 1'b0;
            bus_out      <= '0;
            bus_drive    <= 1'b0;
        end else begin
            addr_latch   <= addr_n;
            ctrl         <= ctrl_n;
            sec          <= sec_n;
            min          <= min_n;
            hour         <= hour_n;
            day          <= day_n;
            month        <= month_n;
            year         <= year_n;
            tick_pending <= tick_pending_n;
            bus_out      <= read_active ? read_val : '0;
            bus_drive    <= read_active;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            div <= '0;
        else if (data_write && (addr_latch == ADDR_SEC))
            div <= '0;
        else if (!ctrl[0])
            div <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder with TICK_DIV=10; inputs change 1 ns
// after rising edges, outputs sampled there as well.
module tb_rtc_bus_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       CS, RD, WR, A_D;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_drive;
    logic       sec_tick;

    int checks = 0;
    int errors = 0;

    rtc_bus_responder #(.TICK_DIV(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .CS        (CS),
        .RD        (RD),
        .WR        (WR),
        .A_D       (A_D),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .bus_drive (bus_drive),
        .sec_tick  (sec_tick)
    );

    always #5 clk = ~clk;

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    // Write event lands on the 5th edge after entry; returns 8 edges after entry.
    task automatic bus_cycle(input logic ad, input logic [7:0] val);
        A_D = ad;
        bus_in = val;
        repeat (2) tick_clk();
        CS = 1'b0;
        WR = 1'b0;
        repeat (4) tick_clk();
        CS = 1'b1;
        WR = 1'b1;
        repeat (2) tick_clk();
    endtask

    task automatic start_read();
        A_D = 1'b1;
        repeat (2) tick_clk();
        CS = 1'b0;
        RD = 1'b0;
        repeat (3) tick_clk();
    endtask

    task automatic end_read();
        RD = 1'b1;
        CS = 1'b1;
        repeat (3) tick_clk();
    endtask

    task automatic read_reg(input logic [7:0] addr, output logic [7:0] data, output logic drv);
        bus_cycle(1'b0, addr);
        start_read();
        data = bus_out;
        drv = bus_drive;
        end_read();
    endtask

    task automatic wait_tick(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick_clk();
            if (sec_tick === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        CS = 1'b1; RD = 1'b1; WR = 1'b1; A_D = 1'b0; bus_in = 8'h00;
        repeat (3) tick_clk();
        checks++;
        if (bus_out !== 8'h00 || bus_drive !== 1'b0 || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got out=%h drv=%b tick=%b exp 00/0/0", bus_out, bus_drive, sec_tick);
        end
        reset = 1'b1;
        tick_clk();
    endtask

    task automatic test_read_latency();
        bus_cycle(1'b0, 8'h24);
        A_D = 1'b1;
        repeat (2) tick_clk();
        CS = 1'b0;
        RD = 1'b0;
        repeat (2) tick_clk();
        checks++;
        if (bus_drive !== 1'b0) begin
            errors++;
            $display("FAIL read_early got drv=%b exp 0", bus_drive);
        end
        tick_clk();
        checks++;
        if (bus_out !== 8'h01 || bus_drive !== 1'b1) begin
            errors++;
            $display("FAIL read_day got out=%h drv=%b exp 01/1", bus_out, bus_drive);
        end
        RD = 1'b1;
        CS = 1'b1;
        repeat (2) tick_clk();
        checks++;
        if (bus_drive !== 1'b1) begin
            errors++;
            $display("FAIL read_hold got drv=%b exp 1", bus_drive);
        end
        tick_clk();
        checks++;
        if (bus_out !== 8'h00 || bus_drive !== 1'b0) begin
            errors++;
            $display("FAIL read_release got out=%h drv=%b exp 00/0", bus_out, bus_drive);
        end
    endtask

    task automatic test_rollover();
        logic [7:0] wa [6];
        logic [7:0] wv [6];
        logic [7:0] ev [6];
        logic [7:0] d;
        logic       drv;
        bit         seen;
        wa = '{8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h21};
        wv = '{8'h59, 8'h23, 8'h31, 8'h12, 8'h99, 8'h59};
        ev = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
        bus_cycle(1'b0, 8'h00);
        bus_cycle(1'b1, 8'h01);
        for (int i = 0; i < 6; i++) begin
            bus_cycle(1'b0, wa[i]);
            bus_cycle(1'b1, wv[i]);
        end
        bus_cycle(1'b0, 8'h00);
        bus_cycle(1'b1, 8'h00);
        wait_tick(seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rollover_tick got none exp pulse");
        end
        bus_cycle(1'b1, 8'h01);
        for (int i = 0; i < 6; i++) begin
            read_reg(8'h21 + 8'(i), d, drv);
            checks++;
            if (d !== ev[i] || drv !== 1'b1) begin
                errors++;
                $display("FAIL rollover_reg%0d got %h/%b exp %h/1", i, d, drv, ev[i]);
            end
        end
    endtask

    task automatic test_halt();
        logic [7:0] d;
        logic       drv;
        int         ticks;
        bus_cycle(1'b0, 8'h21);
        bus_cycle(1'b1, 8'h30);
        ticks = 0;
        for (int i = 0; i < 50; i++) begin
            tick_clk();
            if (sec_tick === 1'b1) ticks++;
        end
        checks++;
        if (ticks != 0) begin
            errors++;
            $display("FAIL halt_ticks got %0d exp 0", ticks);
        end
        read_reg(8'h21, d, drv);
        checks++;
        if (d !== 8'h30) begin
            errors++;
            $display("FAIL halt_sec got %h exp 30", d);
        end
        bus_cycle(1'b0, 8'h00);
        bus_cycle(1'b1, 8'h00);
        ticks = 0;
        for (int i = 0; i < 5; i++) begin
            tick_clk();
            if (sec_tick === 1'b1) ticks++;
        end
        tick_clk();
        checks++;
        if (ticks != 0 || sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL resume_tick got early=%0d tick=%b exp 0/1", ticks, sec_tick);
        end
    endtask

    task automatic test_bcd_inc();
        logic [7:0] d;
        logic       drv;
        bit         seen;
        bus_cycle(1'b0, 8'h21);
        bus_cycle(1'b1, 8'h09);
        start_read();
        checks++;
        if (bus_out !== 8'h09) begin
            errors++;
            $display("FAIL sec_pre got %h exp 09", bus_out);
        end
        wait_tick(seen);
        repeat (2) tick_clk();
        checks++;
        if (!seen || bus_out !== 8'h10) begin
            errors++;
            $display("FAIL sec_09_inc got %h seen=%b exp 10/1", bus_out, seen);
        end
        end_read();
        bus_cycle(1'b1, 8'h7A);
        start_read();
        wait_tick(seen);
        repeat (2) tick_clk();
        checks++;
        if (!seen || bus_out !== 8'h00) begin
            errors++;
            $display("FAIL sec_7a_wrap got %h seen=%b exp 00/1", bus_out, seen);
        end
        end_read();
        read_reg(8'h22, d, drv);
        checks++;
        if (d !== 8'h01) begin
            errors++;
            $display("FAIL min_carry got %h exp 01", d);
        end
    endtask

    task automatic test_tick_write();
        logic [7:0] d;
        logic       drv;
        bit         seen;
        bus_cycle(1'b0, 8'h21);
        bus_cycle(1'b1, 8'h10);
        bus_cycle(1'b0, 8'h22);
        wait_tick(seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL tw_sync got none exp pulse");
        end
        repeat (6) tick_clk();
        A_D = 1'b1;
        bus_in = 8'h45;
        repeat (2) tick_clk();
        CS = 1'b0;
        WR = 1'b0;
        repeat (2) tick_clk();
        checks++;
        if (sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL tw_deferred got tick=%b exp 0", sec_tick);
        end
        tick_clk();
        checks++;
        if (sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL tw_late_pulse got tick=%b exp 1", sec_tick);
        end
        tick_clk();
        checks++;
        if (sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL tw_pulse_end got tick=%b exp 0", sec_tick);
        end
        CS = 1'b1;
        WR = 1'b1;
        repeat (2) tick_clk();
        bus_cycle(1'b0, 8'h00);
        bus_cycle(1'b1, 8'h01);
        read_reg(8'h21, d, drv);
        checks++;
        if (d !== 8'h14) begin
            errors++;
            $display("FAIL tw_sec got %h exp 14", d);
        end
        read_reg(8'h22, d, drv);
        checks++;
        if (d !== 8'h45) begin
            errors++;
            $display("FAIL tw_min got %h exp 45", d);
        end
    endtask

    task automatic test_misc();
        logic [7:0] d;
        logic       drv;
        bus_cycle(1'b0, 8'h00);
        bus_cycle(1'b1, 8'hA5);
        read_reg(8'h00, d, drv);
        checks++;
        if (d !== 8'hA5) begin
            errors++;
            $display("FAIL ctrl_readback got %h exp a5", d);
        end
        bus_cycle(1'b0, 8'h30);
        bus_cycle(1'b1, 8'h55);
        read_reg(8'h30, d, drv);
        checks++;
        if (d !== 8'h00 || drv !== 1'b1) begin
            errors++;
            $display("FAIL unmapped got %h/%b exp 00/1", d, drv);
        end
        A_D = 1'b0;
        CS = 1'b0;
        RD = 1'b0;
        repeat (5) tick_clk();
        checks++;
        if (bus_drive !== 1'b0) begin
            errors++;
            $display("FAIL rd_addr_phase got drv=%b exp 0", bus_drive);
        end
        CS = 1'b1;
        RD = 1'b1;
        A_D = 1'b1;
        repeat (3) tick_clk();
        CS = 1'b0;
        RD = 1'b0;
        WR = 1'b0;
        repeat (5) tick_clk();
        checks++;
        if (bus_drive !== 1'b0) begin
            errors++;
            $display("FAIL rd_wr_both got drv=%b exp 0", bus_drive);
        end
        CS = 1'b1;
        RD = 1'b1;
        WR = 1'b1;
        repeat (3) tick_clk();
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d;
        logic       drv;
        bus_cycle(1'b0, 8'h22);
        start_read();
        checks++;
        if (bus_out !== 8'h45 || bus_drive !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_read got %h/%b exp 45/1", bus_out, bus_drive);
        end
        reset = 1'b0;
        CS = 1'b1;
        RD = 1'b1;
        tick_clk();
        checks++;
        if (bus_out !== 8'h00 || bus_drive !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got %h/%b exp 00/0", bus_out, bus_drive);
        end
        tick_clk();
        reset = 1'b1;
        repeat (3) tick_clk();
        start_read();
        checks++;
        if (bus_out !== 8'h00 || bus_drive !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ctrl got %h/%b exp 00/1", bus_out, bus_drive);
        end
        end_read();
        read_reg(8'h22, d, drv);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_min got %h exp 00", d);
        end
        read_reg(8'h24, d, drv);
        checks++;
        if (d !== 8'h01) begin
            errors++;
            $display("FAIL post_reset_day got %h exp 01", d);
        end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_rollover();
        test_halt();
        test_bcd_inc();
        test_tick_write();
        test_misc();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_bus_responder.md
# rtc_bus_responder

Behavioural-synthesizable responder for the multiplexed address/data RTC bus driven by our timing controller (A_D, CS, RD, WR, 8-bit data out/in). It latches addresses, accepts register writes, returns register reads and keeps BCD time/date counting from a clock-derived one-second tick. It stands in for the external RTC chip in full-system simulation and FPGA loopback, closing the other end of the controller's bus.

## Interface

- TICK_DIV, 100000000: clk cycles per one-second tick; minimum 2.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- CS  input  1  chip select, active low, asynchronous to responder.
- RD  input  1  read strobe, active low.
- WR  input  1  write strobe, active low.
- A_D  input  1  0 = address phase, 1 = data phase.
- bus_in  input  8  bus value from controller (controller's RTC_in).
- bus_out  output  8  read data to controller (controller's RTC_out).
- bus_drive  output  1  1 while bus_out carries valid read data.
- sec_tick  output  1  one-cycle pulse on each one-second tick.

## Operation

- CS, RD, WR, A_D and bus_in pass through 2-flop synchronizers; strobe synchronizer flops reset to 1 (idle), A_D and bus_in stages to 0.
- Write event: synced WR goes 1→0 while synced CS=0. Value used is synced bus_in in the same cycle.
  - A_D=0: address latch ← bus_in.
  - A_D=1: register at latched address ← bus_in (unmapped addresses: ignored).
- Read active: synced CS=0, RD=0, WR=1, A_D=1. bus_out ← register at latched address (unmapped reads 0x00), bus_drive=1. Otherwise bus_out=0x00, bus_drive=0. RD with A_D=0 ignored.
- RD and WR both low: write proceeds, read suppressed.
- Register map: 0x00 control (bit0 = halt; other bits stored, read back), 0x21 seconds, 0x22 minutes, 0x23 hours, 0x24 day, 0x25 month, 0x26 year. All BCD.
- Divider: counts 0..TICK_DIV-1, tick at TICK_DIV-1 then 0. Holds while control bit0=1. Cleared to 0 on any write to 0x21.
- Tick cascade (BCD increment): value ≥ max (unsigned 8-bit compare) → wrap to min and carry; else low nibble 9 → high+1, low 0; else low+1.
  - sec 00–59, min 00–59, hour 00–23, day 01–31, month 01–12, year 00–99. year 99 → 00, no further carry.
  - Day wraps at 31 for every month (no month-length table).
- Tick coincident with a data-phase write event: write applied, tick deferred one cycle (cascade runs next cycle on updated values); sec_tick pulses in the deferred cycle.
- Out-of-range BCD writes stored as-is; next increment wraps per rule above.

## Timing

- Reset (reset=0 at clk edge): address latch 0x00, control 0x00, sec/min/hour/year 0x00, day/month 0x01, divider 0, bus_out 0x00, bus_drive 0, sec_tick 0. Applies mid-transaction; no write event is generated by the first edges after release, since synchronizers restart idle.
- Write latency: register updated on the 3rd rising clk edge after WR falls (2 sync + edge detect), given setup to clk.
- Read latency: bus_out/bus_drive valid 3 clk after last of CS/RD low and A_D high; removed 3 clk after RD or CS rises. bus_out tracks register changes (ticks) while read stays active.
- Controller strobes must stay low ≥3 clk and bus_in stable from ≥2 clk before WR falls until ≥3 clk after; shorter pulses are unsupported.
- sec_tick pulses exactly every TICK_DIV cycles when not halted or cleared.

## Test plan

- Reset then read 0x24 (TICK_DIV=10): address write 0x24, read → bus_out 0x01, bus_drive 1 from 3 clk after RD low; RD high → 0x00/0 after 3 clk.
- Write 0x21←0x59, 0x22←0x59, 0x23←0x23, 0x24←0x31, 0x25←0x12, 0x26←0x99; after one tick read all → 00,00,00,01,01,00.
- Write 0x21←0x09, one tick → 0x10; write 0x21←0x7A, one tick → 0x00 and minutes +1.
- Control 0x00←0x01, wait 5×TICK_DIV → no sec_tick, seconds unchanged; control←0x00 → tick resumes after TICK_DIV.
- Data write to 0x22 in the exact cycle of a tick → written value stored, sec_tick one cycle later, seconds +1.
- Assert reset mid-read with bus_drive=1 → bus_out 0x00, bus_drive 0 next edge; registers at reset values, no spurious write after release.
